wb_arbiter: RTL



---
 rtl/rv_pkg.sv | 23 ++
 rtl/wb_arbiter_if.sv | 28 ++
 rtl/wb_fifo.sv | 71 +++++++
 rtl/wb_arbiter.sv | 132 +++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared register-file and writeback types for the execute, memory and writeback stages.
package rv_pkg;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  typedef enum logic [1:0] {
    WB_SRC_NONE = 2'd0,
    WB_SRC_ALU  = 2'd1,
    WB_SRC_MEM  = 2'd2
  } wb_src_e;

  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
    return NUM_REGS'(1) << rd;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Producer-side and register-file-side signals of the writeback arbiter.
interface wb_arbiter_if;
  import rv_pkg::*;

  logic                  alu_valid;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic [XLEN-1:0]       alu_data;
  logic                  mem_valid;
  logic                  mem_ready;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic [XLEN-1:0]       mem_data;
  logic                  alu_hold;
  logic [NUM_REGS-1:0]   pending_mask;
  logic                  write_reg;
  logic [REG_ADDR_W-1:0] target_reg;
  logic [XLEN-1:0]       write_rd_data;

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input  mem_ready, alu_hold, pending_mask, write_reg, target_reg, write_rd_data
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output mem_ready, alu_hold, pending_mask, write_reg, target_reg, write_rd_data
  );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback requests; exposes head, count and per-entry rd for masking.
module wb_fifo
  import rv_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push,
  input  wb_req_t                          push_req,
  input  logic                             pop,
  output wb_req_t                          head,
  output logic [PTR_W-1:0]                 head_idx,
  output logic [CNT_W-1:0]                 count,
  output logic [DEPTH-1:0]                 ent_valid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_rd
);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;
  wb_req_t          mem_q [DEPTH];

  // Guard against overflow/underflow even if the caller misbehaves.
  always_comb begin
    push_ok  = push && (count_q != CNT_W'(DEPTH));
    pop_ok   = pop && (count_q != '0);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_req;
  end

  assign head     = mem_q[rd_ptr_q];
  assign head_idx = rd_ptr_q;
  assign count    = count_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [PTR_W-1:0] off;
    assign off          = PTR_W'(i) - rd_ptr_q;
    assign ent_valid[i] = {1'b0, off} < count_q;
    assign ent_rd[i]    = mem_q[i].rd;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results win the register-file port, queued long-latency
// results drain into free slots, with starvation protection via alu_hold.
module wb_arbiter
  import rv_pkg::*;
#(
  parameter  int unsigned DEPTH        = 4,
  parameter  int unsigned STARVE_LIMIT = 8,
  localparam int unsigned PTR_W        = $clog2(DEPTH),
  localparam int unsigned CNT_W        = PTR_W + 1,
  localparam int unsigned AGE_W        = $clog2(STARVE_LIMIT + 1)
) (
  input  logic         clk,
  input  logic         rst,
  wb_arbiter_if.slave  bus
);

  wb_req_t                          head;
  wb_req_t                          push_req;
  logic [PTR_W-1:0]                 head_idx;
  logic [CNT_W-1:0]                 count;
  logic [CNT_W-1:0]                 count_nx;
  logic [DEPTH-1:0]                 ent_valid;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_rd;
  wb_src_e                          sel;
  logic                             alu_take, push, pop;

  logic                  write_reg_q,     write_reg_d;
  logic [REG_ADDR_W-1:0] target_reg_q,    target_reg_d;
  logic [XLEN-1:0]       write_rd_data_q, write_rd_data_d;
  logic                  alu_hold_q,      alu_hold_d;
  logic [NUM_REGS-1:0]   pending_mask_q,  pending_mask_d;
  logic                  mem_ready_q,     mem_ready_d;
  logic [AGE_W-1:0]      age_q,           age_d;

  assign push_req = '{rd: bus.mem_rd, data: bus.mem_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_req  (push_req),
    .pop       (pop),
    .head      (head),
    .head_idx  (head_idx),
    .count     (count),
    .ent_valid (ent_valid),
    .ent_rd    (ent_rd)
  );

  // Slot selection and handshakes; rd==0 results are consumed but never written.
  always_comb begin
    alu_take = bus.alu_valid && !alu_hold_q && (bus.alu_rd != '0);
    push     = bus.mem_valid && mem_ready_q && (bus.mem_rd != '0);
    sel      = WB_SRC_NONE;
    if (alu_take)           sel = WB_SRC_ALU;
    else if (count != '0)   sel = WB_SRC_MEM;
    pop      = (sel == WB_SRC_MEM);
  end

  always_comb begin
    write_reg_d     = 1'b0;
    target_reg_d    = '0;
    write_rd_data_d = '0;
    case (sel)
      WB_SRC_ALU: begin
        write_reg_d     = 1'b1;
        target_reg_d    = bus.alu_rd;
        write_rd_data_d = bus.alu_data;
      end
      WB_SRC_MEM: begin
        write_reg_d     = 1'b1;
        target_reg_d    = head.rd;
        write_rd_data_d = head.data;
      end
      default: ;
    endcase
  end

  // Occupancy after this edge drives ready/hold so both reflect registered state only.
  always_comb begin
    count_nx    = count + CNT_W'(push) - CNT_W'(pop);
    mem_ready_d = count_nx < CNT_W'(DEPTH);

    age_d = age_q;
    if ((count == '0) || pop)              age_d = '0;
    else if (age_q < AGE_W'(STARVE_LIMIT)) age_d = age_q + AGE_W'(1);

    alu_hold_d = (count_nx == CNT_W'(DEPTH)) || (age_d >= AGE_W'(STARVE_LIMIT));
  end

  // Mask of entries surviving this edge, plus the one being accepted.
  always_comb begin
    pending_mask_d = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ent_valid[PTR_W'(i)] && !(pop && (head_idx == PTR_W'(i))))
        pending_mask_d |= rd_onehot(ent_rd[PTR_W'(i)]);
    end
    if (push) pending_mask_d |= rd_onehot(bus.mem_rd);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_reg_q     <= 1'b0;
      target_reg_q    <= '0;
      write_rd_data_q <= '0;
      alu_hold_q      <= 1'b0;
      pending_mask_q  <= '0;
      mem_ready_q     <= 1'b1;
      age_q           <= '0;
    end else begin
      write_reg_q     <= write_reg_d;
      target_reg_q    <= target_reg_d;
      write_rd_data_q <= write_rd_data_d;
      alu_hold_q      <= alu_hold_d;
      pending_mask_q  <= pending_mask_d;
      mem_ready_q     <= mem_ready_d;
      age_q           <= age_d;
    end
  end

  assign bus.write_reg     = write_reg_q;
  assign bus.target_reg    = target_reg_q;
  assign bus.write_rd_data = write_rd_data_q;
  assign bus.alu_hold      = alu_hold_q;
  assign bus.pending_mask  = pending_mask_q;
  assign bus.mem_ready     = mem_ready_q;

  // Upstream must honour alu_hold; a result offered during hold is dropped.
  a_no_alu_during_hold: assert property (@(posedge clk) disable iff (!rst)
    !(bus.alu_valid && alu_hold_q));

endmodule
